// File: rtl/vga_text_pkg.sv
// -----------------------------------------------------------------------------
// vga_text_pkg
// Shared definitions for the 80x60 VGA text console: screen geometry, fill
// character, control codes, FSM state encoding and cursor/address helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package vga_text_pkg;

   localparam int COLS  = 80;
   localparam int ROWS  = 60;
   localparam int CELLS = COLS * ROWS;

   localparam logic [7:0] BLANK_CHAR = 8'h20;

   localparam logic [7:0] CC_BS  = 8'h08;
   localparam logic [7:0] CC_TAB = 8'h09;
   localparam logic [7:0] CC_LF  = 8'h0A;
   localparam logic [7:0] CC_FF  = 8'h0C;
   localparam logic [7:0] CC_CR  = 8'h0D;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PUT,
      ST_SCR_RD,
      ST_SCR_WR,
      ST_FILL
   } state_t;

   // Cursor word consumed by the VGA stage: {row[5:0], col[6:0]}.
   function automatic logic [12:0] pack_cursor(input logic [5:0] row,
                                                input logic [6:0] col);
      return {row, col};
   endfunction

   // row*80 as (row<<6)+(row<<4); 59*80 = 4720 fits easily in 13 bits.
   function automatic logic [12:0] row_base(input logic [5:0] row);
      logic [12:0] r;
      r = {7'd0, row};
      return (r << 6) + (r << 4);
   endfunction

endpackage

// File: rtl/vga_blink_gen.sv
// -----------------------------------------------------------------------------
// vga_blink_gen
// Free-running cursor blink generator: a counter runs 0..BLINK_DIV-1 and the
// blink phase toggles each time it wraps.
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous reset, active low
//   blink  out  cursor blink phase
// -----------------------------------------------------------------------------
module vga_blink_gen #(
   parameter int BLINK_DIV = 25000000
) (
   input  logic clk,
   input  logic rst,
   output logic blink
);

   localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(BLINK_DIV - 1);

   logic [CW-1:0] r_cnt;
   logic          r_blink;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt   <= '0;
         r_blink <= 1'b0;
      end else if (r_cnt == LAST) begin
         r_cnt   <= '0;
         r_blink <= ~r_blink;
      end else begin
         r_cnt   <= r_cnt + 1'b1;
      end
   end

   assign blink = r_blink;

endmodule

// File: rtl/vga_text_console.sv
// -----------------------------------------------------------------------------
// vga_text_console
// Character-terminal engine feeding 80x60 text VRAM with {attr, char} words.
// Handles printable bytes with line wrap, LF/CR/BS/FF control codes, a
// full-screen scroll-up (read row below, write row above, blank last row) and
// a full-screen clear. Exports the cursor and the blink phase to the VGA stage.
// Build option: define CONSOLE_TAB_EN to make 8'h09 a tab to the next
// multiple-of-8 column; otherwise 8'h09 is an ordinary printable byte.
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous reset, active low
//   char_valid  in   byte offered
//   char_data   in   character or control code
//   char_attr   in   attribute byte, VRAM word [15:8]
//   char_ready  out  console can accept a byte (IDLE)
//   vram_we     out  VRAM write strobe
//   vram_re     out  VRAM read strobe
//   vram_addr   out  VRAM word address = row*80 + col
//   vram_wdata  out  {attr, char}
//   vram_rdata  in   read data, valid one cycle after vram_re
//   cursor      out  {row[5:0], col[6:0]}
//   blink       out  cursor blink phase
//   busy        out  scroll or clear in progress
// -----------------------------------------------------------------------------
module vga_text_console
   import vga_text_pkg::*;
#(
   parameter int BLINK_DIV = 25000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        char_valid,
   input  logic [7:0]  char_data,
   input  logic [7:0]  char_attr,
   output logic        char_ready,
   output logic        vram_we,
   output logic        vram_re,
   output logic [12:0] vram_addr,
   output logic [15:0] vram_wdata,
   input  logic [15:0] vram_rdata,
   output logic [12:0] cursor,
   output logic        blink,
   output logic        busy
);

   state_t      r_state;
   state_t      w_next;
   logic [5:0]  r_row;
   logic [6:0]  r_col;
   logic [7:0]  r_char;
   logic [7:0]  r_attr;
   logic [12:0] r_idx;       // scroll/fill word index

   logic        w_accept;
   logic        w_last_row;
   logic        w_col_end;
   logic        w_is_lf;
   logic        w_is_cr;
   logic        w_is_bs;
   logic        w_is_ff;
   logic        w_is_tab;
   logic        w_tab_wrap;
   logic [6:0]  w_tab_col;
   logic        w_is_print;
   logic        w_newline;
   logic        w_scroll;
   logic [12:0] w_cell;

   assign w_accept   = char_valid && (r_state == ST_IDLE);
   assign w_last_row = (r_row == 6'(ROWS - 1));
   assign w_col_end  = (r_col == 7'(COLS - 1));
   assign w_cell     = row_base(r_row) + {6'd0, r_col};

   assign w_is_lf = (r_char == CC_LF);
   assign w_is_cr = (r_char == CC_CR);
   assign w_is_bs = (r_char == CC_BS);
   assign w_is_ff = (r_char == CC_FF);

`ifdef CONSOLE_TAB_EN
   logic [7:0] w_tab_next;
   assign w_tab_next = {1'b0, r_col[6:3], 3'b000} + 8'd8;
   assign w_is_tab   = (r_char == CC_TAB);
   assign w_tab_wrap = (w_tab_next >= 8'(COLS));
   assign w_tab_col  = w_tab_next[6:0];
`else
   assign w_is_tab   = 1'b0;
   assign w_tab_wrap = 1'b0;
   assign w_tab_col  = r_col;
`endif

   assign w_is_print = !(w_is_lf || w_is_cr || w_is_bs || w_is_ff || w_is_tab);

   // Anything that moves to column 0 of the next row: LF, a tab past the
   // last column, or a printable landing in the last column.
   assign w_newline = w_is_lf || (w_is_tab && w_tab_wrap) ||
                      (w_is_print && w_col_end);
   assign w_scroll  = w_newline && w_last_row;

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_next;
   end

   // ----------------------------------------------------------- next state
   // NOTE: every combinational output gets a default before the case so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   if (w_accept) w_next = ST_PUT;
         ST_PUT: begin
            if (w_is_ff)       w_next = ST_FILL;
            else if (w_scroll) w_next = ST_SCR_RD;
            else               w_next = ST_IDLE;
         end
         ST_SCR_RD: w_next = ST_SCR_WR;
         ST_SCR_WR: w_next = (r_idx == 13'(CELLS - COLS - 1)) ? ST_FILL : ST_SCR_RD;
         ST_FILL:   if (r_idx == 13'(CELLS - 1)) w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_row  <= '0;
         r_col  <= '0;
         r_char <= '0;
         r_attr <= '0;
         r_idx  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_char <= char_data;
                  r_attr <= char_attr;
               end
            end
            ST_PUT: begin
               r_idx <= '0;
               if (w_newline) begin
                  r_col <= '0;
                  if (!w_last_row) r_row <= r_row + 6'd1;
               end else if (w_is_cr) begin
                  r_col <= '0;
               end else if (w_is_bs) begin
                  if (r_col != 7'd0) r_col <= r_col - 7'd1;
               end else if (w_is_tab) begin
                  r_col <= w_tab_col;
               end else if (w_is_print) begin
                  r_col <= r_col + 7'd1;
               end
            end
            ST_SCR_WR: r_idx <= r_idx + 13'd1;
            ST_FILL: begin
               r_idx <= r_idx + 13'd1;
               // Scroll leaves the cursor on the last row; clear homes it.
               if (r_idx == 13'(CELLS - 1) && w_is_ff) begin
                  r_row <= '0;
                  r_col <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // -------------------------------------------------------------- outputs
   always_comb begin
      vram_we    = 1'b0;
      vram_re    = 1'b0;
      vram_addr  = '0;
      vram_wdata = '0;
      case (r_state)
         ST_PUT: begin
            if (w_is_print) begin
               vram_we    = 1'b1;
               vram_addr  = w_cell;
               vram_wdata = {r_attr, r_char};
            end else if (w_is_bs && r_col != 7'd0) begin
               vram_we    = 1'b1;
               vram_addr  = w_cell - 13'd1;
               vram_wdata = {r_attr, BLANK_CHAR};
            end
         end
         ST_SCR_RD: begin
            vram_re   = 1'b1;
            vram_addr = r_idx + 13'(COLS);
         end
         ST_SCR_WR: begin
            vram_we    = 1'b1;
            vram_addr  = r_idx;
            vram_wdata = vram_rdata;
         end
         ST_FILL: begin
            vram_we    = 1'b1;
            vram_addr  = r_idx;
            vram_wdata = {r_attr, BLANK_CHAR};
         end
         default: ;
      endcase
   end

   assign char_ready = (r_state == ST_IDLE);
   assign busy       = (r_state == ST_SCR_RD) || (r_state == ST_SCR_WR) ||
                       (r_state == ST_FILL);
   assign cursor     = pack_cursor(r_row, r_col);

   vga_blink_gen #(
      .BLINK_DIV (BLINK_DIV)
   ) u_blink (
      .clk   (clk),
      .rst   (rst),
      .blink (blink)
   );

endmodule

// File: tb/tb_vga_text_console.sv
// -----------------------------------------------------------------------------
// tb_vga_text_console
// Directed bench for vga_text_console with a behavioural VRAM (one-cycle read
// latency). Honours CONSOLE_TAB_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_vga_text_console;
   import vga_text_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        char_valid = 1'b0;
   logic [7:0]  char_data = 8'h00;
   logic [7:0]  char_attr = 8'h00;
   logic        char_ready;
   logic        vram_we;
   logic        vram_re;
   logic [12:0] vram_addr;
   logic [15:0] vram_wdata;
   logic [15:0] vram_rdata = 16'h0000;
   logic [12:0] cursor;
   logic        blink;
   logic        busy;

   always #5 clk = ~clk;

   vga_text_console #(
      .BLINK_DIV (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .char_valid (char_valid),
      .char_data  (char_data),
      .char_attr  (char_attr),
      .char_ready (char_ready),
      .vram_we    (vram_we),
      .vram_re    (vram_re),
      .vram_addr  (vram_addr),
      .vram_wdata (vram_wdata),
      .vram_rdata (vram_rdata),
      .cursor     (cursor),
      .blink      (blink),
      .busy       (busy)
   );

   // ---------------------------------------------------------- VRAM model
   logic [15:0] mem   [0:CELLS-1];
   logic [15:0] prior [0:CELLS-1];
   logic        preload = 1'b1;

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < CELLS; i++) mem[i] <= 16'h8000 | 16'(i);
      end else begin
         if (vram_we && vram_addr < 13'(CELLS)) mem[vram_addr] <= vram_wdata;
         if (vram_re && vram_addr < 13'(CELLS)) vram_rdata <= mem[vram_addr];
      end
   end

   int n_overlap = 0;
   int n_oob     = 0;
   always @(negedge clk) begin
      if (rst) begin
         if (vram_we && vram_re) n_overlap++;
         if ((vram_we || vram_re) && vram_addr >= 13'(CELLS)) n_oob++;
      end
   end

   // ------------------------------------------------------------ checking
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Outputs seen during the PUT cycle of the last byte sent.
   logic        cap_we;
   logic [12:0] cap_addr;
   logic [15:0] cap_wdata;
   logic        cap_ready;

   // Called and returns at a negedge; returns inside the PUT cycle.
   task automatic send(input logic [7:0] c, input logic [7:0] a);
      int n;
      n = 0;
      while (!char_ready && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (!char_ready) begin
         check("ready_timeout", 32'(char_ready), 1);
         return;
      end
      char_valid = 1'b1;
      char_data  = c;
      char_attr  = a;
      @(posedge clk);
      @(negedge clk);
      char_valid = 1'b0;
      cap_we     = vram_we;
      cap_addr   = vram_addr;
      cap_wdata  = vram_wdata;
      cap_ready  = char_ready;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!char_ready && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (!char_ready) check("idle_timeout", 32'(char_ready), 1);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // -------------------------------------------------------------- stimulus
   initial begin
      int n_busy;
      int n_fill;
      int n_seq;
      int bad;

      repeat (3) @(negedge clk);
      check("rst_cursor", 32'(cursor), 0);
      check("rst_we",     32'(vram_we), 0);
      check("rst_re",     32'(vram_re), 0);
      check("rst_addr",   32'(vram_addr), 0);
      check("rst_wdata",  32'(vram_wdata), 0);
      check("rst_busy",   32'(busy), 0);
      check("rst_blink",  32'(blink), 0);
      preload = 1'b0;
      rst     = 1'b1;
      check("ready_after_rst", 32'(char_ready), 1);

      // Blink with BLINK_DIV=4: after k edges blink = (k/4) mod 2.
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         check($sformatf("blink_k%0d", k), 32'(blink), (k / 4) % 2);
      end

      // 'A' at home position.
      send(8'h41, 8'h07);
      check("a_we",        32'(cap_we), 1);
      check("a_addr",      32'(cap_addr), 0);
      check("a_wdata",     32'(cap_wdata), 32'h0741);
      check("a_ready_put", 32'(cap_ready), 0);
      @(negedge clk);
      check("a_cursor",    32'(cursor), 32'h0001);
      check("a_ready",     32'(char_ready), 1);
      check("a_mem",       32'(mem[0]), 32'h0741);

      // Move to row 3, col 79; CR must not write.
      send(CC_CR, 8'h07);
      check("cr_we", 32'(cap_we), 0);
      repeat (3) send(CC_LF, 8'h07);
      repeat (79) send(8'h61, 8'h07);
      wait_idle();
      check("pre_z_cursor", 32'(cursor), 32'({6'd3, 7'd79}));

      // 'Z' in the last column wraps without scrolling.
      send(8'h5A, 8'h07);
      check("z_we",    32'(cap_we), 1);
      check("z_addr",  32'(cap_addr), 319);
      check("z_wdata", 32'(cap_wdata), 32'h075A);
      @(negedge clk);
      check("z_cursor", 32'(cursor), 32'({6'd4, 7'd0}));
      check("z_busy",   32'(busy), 0);
      check("z_ready",  32'(char_ready), 1);

      // Down to the last row, then LF triggers a scroll.
      repeat (55) send(CC_LF, 8'h07);
      wait_idle();
      check("pre_scroll_cursor", 32'(cursor), 32'({6'd59, 7'd0}));
      for (int i = 0; i < CELLS; i++) prior[i] = mem[i];
      send(CC_LF, 8'h1E);
      check("lf_put_we", 32'(cap_we), 0);
      n_busy = 0;
      @(negedge clk);
      while (busy && n_busy < 20000) begin
         n_busy++;
         @(negedge clk);
      end
      check("scroll_cycles", 32'(n_busy), 9520);
      bad = 0;
      for (int k = 0; k < CELLS - COLS; k++) if (mem[k] !== prior[k + COLS]) bad++;
      check("scroll_copy", 32'(bad), 0);
      bad = 0;
      for (int k = CELLS - COLS; k < CELLS; k++) if (mem[k] !== 16'h1E20) bad++;
      check("scroll_blank", 32'(bad), 0);
      check("scroll_cursor", 32'(cursor), 32'({6'd59, 7'd0}));

      // Backspace at column 0 does nothing; at column 5 blanks column 4.
      send(CC_BS, 8'h07);
      check("bs0_we", 32'(cap_we), 0);
      @(negedge clk);
      check("bs0_cursor", 32'(cursor), 32'({6'd59, 7'd0}));
      repeat (5) send(8'h62, 8'h07);
      send(CC_BS, 8'h07);
      check("bs_we",    32'(cap_we), 1);
      check("bs_addr",  32'(cap_addr), 4724);
      check("bs_wdata", 32'(cap_wdata), 32'h0720);
      @(negedge clk);
      check("bs_cursor", 32'(cursor), 32'({6'd59, 7'd4}));

      // 8'h09 from column 3.
      send(CC_CR, 8'h07);
      repeat (3) send(8'h62, 8'h07);
      send(CC_TAB, 8'h07);
`ifdef CONSOLE_TAB_EN
      check("tab_we", 32'(cap_we), 0);
      @(negedge clk);
      check("tab_cursor", 32'(cursor), 32'({6'd59, 7'd8}));
`else
      check("tab_we",    32'(cap_we), 1);
      check("tab_addr",  32'(cap_addr), 4723);
      check("tab_wdata", 32'(cap_wdata), 32'h0709);
      @(negedge clk);
      check("tab_cursor", 32'(cursor), 32'({6'd59, 7'd4}));
`endif

      // Full clear: 4800 consecutive blank writes at ascending addresses.
      send(CC_FF, 8'h2F);
      check("ff_put_we", 32'(cap_we), 0);
      n_fill = 0;
      n_seq  = 0;
      @(negedge clk);
      while (busy && n_fill < 6000) begin
         if (vram_we && !vram_re && vram_addr == 13'(n_fill) &&
             vram_wdata == 16'h2F20) n_seq++;
         n_fill++;
         @(negedge clk);
      end
      check("ff_cycles", 32'(n_fill), 4800);
      check("ff_writes", 32'(n_seq), 4800);
      check("ff_cursor", 32'(cursor), 0);
      bad = 0;
      for (int k = 0; k < CELLS; k++) if (mem[k] !== 16'h2F20) bad++;
      check("ff_mem", 32'(bad), 0);

      // Clear interrupted by reset: writes stop immediately.
      send(CC_FF, 8'h2F);
      repeat (1000) @(negedge clk);
      check("mid_we",   32'(vram_we), 1);
      check("mid_busy", 32'(busy), 1);
      #2 rst = 1'b0;
      #1;
      check("abort_we",     32'(vram_we), 0);
      check("abort_busy",   32'(busy), 0);
      check("abort_cursor", 32'(cursor), 0);
      check("abort_addr",   32'(vram_addr), 0);
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (vram_we || vram_re) bad++;
      end
      rst = 1'b1;
      @(negedge clk);
      if (vram_we || vram_re || busy) bad++;
      check("abort_no_writes", 32'(bad), 0);
      check("abort_ready", 32'(char_ready), 1);

      check("we_re_overlap", 32'(n_overlap), 0);
      check("addr_range",    32'(n_oob), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
